d4_distributor: RTL and testbench

One-to-four registered distributor: accepts N-bit words on a valid/ready input and stores each word into one of four output lane registers. The lane is chosen by the same select gating as the S2 mux cell (S1 = A1 | B1, lane bit 0 = A0 & B0). Each lane exposes its own valid/ready handshake. It is the fan-out counterpart to the S2-style 4:1 registered selector and feeds four downstream consumers from one producer.

---
 rtl/d4_pkg.sv | 16 +
 rtl/d4_distributor_if.sv | 35 +++
 rtl/d4_lane.sv | 51 +++++
 rtl/d4_distributor.sv | 60 ++++++
 tb/tb_d4_distributor.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/d4_pkg.sv
// Shared types and helpers for the d4_distributor one-to-four registered fan-out.
// Used by d4_distributor_if, d4_lane and d4_distributor.
package d4_pkg;

  localparam int LANE_CNT = 4;
  localparam int CNT_W    = 8;

  typedef logic [1:0] lane_idx_t;

  // Same gating as the S2 mux select: bit 1 is an OR pair, bit 0 an AND pair.
  function automatic lane_idx_t lane_sel(input logic a1, input logic b1,
                                         input logic a0, input logic b0);
    return lane_idx_t'({a1 | b1, a0 & b0});
  endfunction

endpackage

// File: rtl/d4_distributor_if.sv
// Producer-side and four-lane consumer-side signals of d4_distributor.
// The per-lane counter outputs exist only when DIST_CNT_EN is defined.
interface d4_distributor_if
  import d4_pkg::*;
#(
  parameter int N = 8
);
  logic [N-1:0]        in_data;
  logic                in_valid;
  logic                in_ready;
  logic                A1, B1, A0, B0;
  logic [N-1:0]        Q00, Q01, Q10, Q11;
  logic [LANE_CNT-1:0] out_valid;
  logic [LANE_CNT-1:0] out_ready;
`ifdef DIST_CNT_EN
  logic [CNT_W-1:0]    cnt00, cnt01, cnt10, cnt11;
`endif

  modport master (
    output in_data, in_valid, A1, B1, A0, B0, out_ready,
    input  in_ready, Q00, Q01, Q10, Q11, out_valid
`ifdef DIST_CNT_EN
    , input cnt00, cnt01, cnt10, cnt11
`endif
  );

  modport slave (
    input  in_data, in_valid, A1, B1, A0, B0, out_ready,
    output in_ready, Q00, Q01, Q10, Q11, out_valid
`ifdef DIST_CNT_EN
    , output cnt00, cnt01, cnt10, cnt11
`endif
  );

endinterface

// File: rtl/d4_lane.sv
// One output lane: data register, valid bit and (with DIST_CNT_EN) an 8-bit
// wrapping accept counter. Load takes priority over drain on the same edge.
module d4_lane
  import d4_pkg::*;
#(
  parameter int N = 8
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             i_load,
  input  logic             i_drain,
  input  logic [N-1:0]     i_data,
  output logic [N-1:0]     o_q,
  output logic             o_valid
`ifdef DIST_CNT_EN
  , output logic [CNT_W-1:0] o_cnt
`endif
);

  logic [N-1:0] r_q;
  logic         r_valid;

  // NOTE: non-blocking assignments so every lane updates from pre-edge values.
  // NOTE: the data register is reset too, because Q must read 0 after CLR.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_q     <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_q     <= i_data;
      r_valid <= 1'b1;
    end else if (i_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_q     = r_q;
  assign o_valid = r_valid;

`ifdef DIST_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (CLR)         r_cnt <= '0;
    else if (i_load) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign o_cnt = r_cnt;
`endif

endmodule

// File: rtl/d4_distributor.sv
// One-to-four registered distributor: lane decode, in_ready and four d4_lane
// instances. Optional per-lane accept counters under DIST_CNT_EN.
module d4_distributor
  import d4_pkg::*;
#(
  parameter int N = 8
) (
  input logic               CLK,
  input logic               CLR,
  d4_distributor_if.slave   bus
);

  lane_idx_t           w_lane;
  logic                w_lane_free;
  logic                w_accept;
  logic [LANE_CNT-1:0] w_load;
  logic [LANE_CNT-1:0] w_drain;
  logic [LANE_CNT-1:0] w_valid;
  logic [N-1:0]        w_q [LANE_CNT];
`ifdef DIST_CNT_EN
  logic [CNT_W-1:0]    w_cnt [LANE_CNT];
`endif

  // A draining lane is free, so one lane can stream a word every cycle.
  assign w_lane      = lane_sel(bus.A1, bus.B1, bus.A0, bus.B0);
  assign w_lane_free = ~w_valid[w_lane] | bus.out_ready[w_lane];
  assign bus.in_ready = ~CLR & w_lane_free;
  assign w_accept    = bus.in_valid & bus.in_ready;
  assign w_drain     = w_valid & bus.out_ready;

  for (genvar g = 0; g < LANE_CNT; g++) begin : g_lane
    assign w_load[g] = w_accept & (w_lane == lane_idx_t'(g));

    d4_lane #(.N(N)) u_lane (
      .CLK     (CLK),
      .CLR     (CLR),
      .i_load  (w_load[g]),
      .i_drain (w_drain[g]),
      .i_data  (bus.in_data),
      .o_q     (w_q[g]),
      .o_valid (w_valid[g])
`ifdef DIST_CNT_EN
      , .o_cnt (w_cnt[g])
`endif
    );
  end

  assign bus.out_valid = w_valid;
  assign bus.Q00 = w_q[0];
  assign bus.Q01 = w_q[1];
  assign bus.Q10 = w_q[2];
  assign bus.Q11 = w_q[3];
`ifdef DIST_CNT_EN
  assign bus.cnt00 = w_cnt[0];
  assign bus.cnt01 = w_cnt[1];
  assign bus.cnt10 = w_cnt[2];
  assign bus.cnt11 = w_cnt[3];
`endif

endmodule

// File: tb/tb_d4_distributor.sv
// Self-checking bench for d4_distributor: scenario tasks plus a per-lane
// scoreboard that checks every word a consumer takes. Exercises DIST_CNT_EN if defined.
module tb_d4_distributor;

  logic clk;
  logic clr;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  d4_distributor_if #(.N(8)) bus ();

  d4_distributor #(.N(8)) dut (
    .CLK (clk),
    .CLR (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: words expected at each lane, pushed on modelled accept.
  logic [7:0] sb [4][$];
  logic [3:0] m_valid = 4'b0000;

  function automatic logic [7:0] lane_q(input int i);
    case (i)
      0:       return bus.Q00;
      1:       return bus.Q01;
      2:       return bus.Q10;
      default: return bus.Q11;
    endcase
  endfunction

  // Inputs change only at posedge+1, so negedge sees what the next edge will use.
  always @(negedge clk) begin
    logic [1:0] ln;
    logic       exp_rdy;
    logic [7:0] exp_w;
    if (mon_en) begin
      ln      = {bus.A1 | bus.B1, bus.A0 & bus.B0};
      exp_rdy = !clr && (!m_valid[ln] || bus.out_ready[ln]);
      n_checks++;
      if (bus.out_valid !== m_valid) begin
        n_fail++;
        $display("FAIL mon_out_valid: got %b expected %b at %0t", bus.out_valid, m_valid, $time);
      end
      n_checks++;
      if (bus.in_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL mon_in_ready: got %b expected %b at %0t", bus.in_ready, exp_rdy, $time);
      end
      if (clr) begin
        for (int i = 0; i < 4; i++) sb[i].delete();
        m_valid = 4'b0000;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (m_valid[i] && bus.out_ready[i]) begin
            n_checks++;
            if (sb[i].size() == 0) begin
              n_fail++;
              $display("FAIL mon_take_lane%0d: got %h expected empty scoreboard", i, lane_q(i));
            end else begin
              exp_w = sb[i].pop_front();
              if (lane_q(i) !== exp_w) begin
                n_fail++;
                $display("FAIL mon_take_lane%0d: got %h expected %h at %0t", i, lane_q(i), exp_w, $time);
              end
            end
            m_valid[i] = 1'b0;
          end
        end
        if (bus.in_valid && exp_rdy) begin
          sb[ln].push_back(bus.in_data);
          m_valid[ln] = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input logic [3:0] s);
    {bus.A1, bus.B1, bus.A0, bus.B0} = s;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h55;
    bus.out_ready = 4'b0000;
    set_sel(4'b0000);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
    end
    step();
    clr = 1'b0;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 4'b0000) begin
      n_fail++; $display("FAIL reset_out_valid: got %b expected 0000", bus.out_valid);
    end
    n_checks++;
    if ({bus.Q00, bus.Q01, bus.Q10, bus.Q11} !== 32'h0) begin
      n_fail++; $display("FAIL reset_q: got %h expected 00000000", {bus.Q00, bus.Q01, bus.Q10, bus.Q11});
    end
    mon_en = 1'b1;
    step();
    n_checks++;
    if (bus.out_valid !== 4'b0000) begin
      n_fail++; $display("FAIL reset_no_accept: got %b expected 0000", bus.out_valid);
    end
  endtask

  task automatic test_lane_decode();
    logic [3:0] sels [4];
    sels = '{4'b0000, 4'b0011, 4'b1000, 4'b0111};
    for (int i = 0; i < 4; i++) begin
      set_sel(sels[i]);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hA0 + 8'(i);
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
        n_fail++; $display("FAIL decode_in_ready_%0d: got %b expected 1", i, bus.in_ready);
      end
      step();
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if ({bus.Q00, bus.Q01, bus.Q10, bus.Q11} !== 32'hA0A1A2A3) begin
      n_fail++; $display("FAIL decode_q: got %h expected a0a1a2a3", {bus.Q00, bus.Q01, bus.Q10, bus.Q11});
    end
    n_checks++;
    if (bus.out_valid !== 4'b1111) begin
      n_fail++; $display("FAIL decode_out_valid: got %b expected 1111", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    set_sel(4'b1000);
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hC5;
    bus.out_ready = 4'b0000;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_blocked_ready: got %b expected 0", bus.in_ready);
    end
    step();
    n_checks++;
    if (bus.Q10 !== 8'hA2) begin
      n_fail++; $display("FAIL bp_q10_held: got %h expected a2", bus.Q10);
    end
    bus.out_ready = 4'b0100;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_drain_ready: got %b expected 1", bus.in_ready);
    end
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0000;
    n_checks++;
    if (bus.Q10 !== 8'hC5) begin
      n_fail++; $display("FAIL bp_q10_new: got %h expected c5", bus.Q10);
    end
    n_checks++;
    if (bus.out_valid !== 4'b1111) begin
      n_fail++; $display("FAIL bp_out_valid: got %b expected 1111", bus.out_valid);
    end
  endtask

  task automatic test_streaming();
    set_sel(4'b0011);
    bus.out_ready = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i);
      #1;
      n_checks++;
      if (bus.in_ready !== 1'b1) begin
        n_fail++; $display("FAIL stream_ready_%0d: got %b expected 1", i, bus.in_ready);
      end
      step();
      n_checks++;
      if (bus.Q01 !== 8'(i) || bus.out_valid[1] !== 1'b1) begin
        n_fail++; $display("FAIL stream_q01_%0d: got %h/%b expected %h/1", i, bus.Q01, bus.out_valid[1], 8'(i));
      end
    end
    bus.in_valid = 1'b0;
    step();
    bus.out_ready = 4'b0000;
    n_checks++;
    if (bus.out_valid !== 4'b1101) begin
      n_fail++; $display("FAIL stream_drained: got %b expected 1101", bus.out_valid);
    end
  endtask

  task automatic test_mid_reset();
    set_sel(4'b0011);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    step();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 4'b1111) begin
      n_fail++; $display("FAIL mid_full: got %b expected 1111", bus.out_valid);
    end
    clr = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 4'b1111;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL mid_clr_ready: got %b expected 0", bus.in_ready);
    end
    step();
    clr = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0000;
    n_checks++;
    if (bus.out_valid !== 4'b0000) begin
      n_fail++; $display("FAIL mid_out_valid: got %b expected 0000", bus.out_valid);
    end
    n_checks++;
    if ({bus.Q00, bus.Q01, bus.Q10, bus.Q11} !== 32'h0) begin
      n_fail++; $display("FAIL mid_q: got %h expected 00000000", {bus.Q00, bus.Q01, bus.Q10, bus.Q11});
    end
    set_sel(4'b0111);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h3C;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_after_ready: got %b expected 1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.Q11 !== 8'h3C || bus.out_valid !== 4'b1000) begin
      n_fail++; $display("FAIL mid_after_accept: got %h/%b expected 3c/1000", bus.Q11, bus.out_valid);
    end
  endtask

`ifdef DIST_CNT_EN
  task automatic test_counters();
    clr = 1'b1;
    step();
    clr = 1'b0;
    set_sel(4'b0000);
    bus.out_ready = 4'b0001;
    for (int i = 0; i < 257; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'(i);
      step();
    end
    bus.in_valid = 1'b0;
    step();
    bus.out_ready = 4'b0000;
    n_checks++;
    if (bus.cnt00 !== 8'd1) begin
      n_fail++; $display("FAIL cnt00_wrap: got %0d expected 1", bus.cnt00);
    end
    n_checks++;
    if ({bus.cnt01, bus.cnt10, bus.cnt11} !== 24'h0) begin
      n_fail++; $display("FAIL cnt_others: got %h expected 000000", {bus.cnt01, bus.cnt10, bus.cnt11});
    end
  endtask
`endif

  initial begin
    clr           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 4'b0000;
    set_sel(4'b0000);
    test_reset();
    test_lane_decode();
    test_backpressure();
    test_streaming();
    test_mid_reset();
`ifdef DIST_CNT_EN
    test_counters();
`endif
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
